keypad_entry_controller: RTL and testbench

Sequences the 10-key priority encoder for the timer-entry path. Debounces each encoded key, accepts one digit per press/release cycle, and shifts accepted digits into a 4-digit BCD MM:SS entry register. On start, validates the entry and hands it to the countdown timer. Sits between the keypad priority encoder and the timer/control block, and disables the encoder while the timer runs.

---
 rtl/keypad_entry_controller_if.sv | 22 ++
 rtl/keypad_entry_controller.sv | 197 +++++++++++++++++++
 tb/tb_keypad_entry_controller.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_entry_controller_if.sv
// Encoder-side link of the keypad entry controller.
//   enc_bcd      : digit code 0-9 from the priority encoder
//   enc_datavaln : active-low, exactly one key pressed
//   enc_enablen  : active-low encoder enable, driven by the controller
// master = controller side, slave = encoder side.
interface keypad_entry_controller_if;
  logic [3:0] enc_bcd;
  logic       enc_datavaln;
  logic       enc_enablen;

  modport master (
    input  enc_bcd,
    input  enc_datavaln,
    output enc_enablen
  );

  modport slave (
    output enc_bcd,
    output enc_datavaln,
    input  enc_enablen
  );
endinterface

// File: rtl/keypad_entry_controller.sv
// Keypad entry controller for the timer-entry path.
// Debounces the encoded key, accepts one digit per press/release cycle,
// shifts digits into a 4-digit BCD MM:SS entry register and hands a
// validated entry to the countdown timer on a start request.
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   enc           : encoder link (enc_bcd, enc_datavaln in; enc_enablen out)
//   start         : start request level, acted on at its rising edge
//   clear         : clear entry, level-sensitive
//   timer_busy    : countdown running; locks the controller
//   digits        : {min_tens, min_ones, sec_tens, sec_ones}
//   digit_count   : number of digits entered, 0-4
//   key_strobe    : one-cycle pulse per accepted digit
//   load_strobe   : one-cycle pulse, time_load valid
//   time_load     : entry snapshot taken at a successful start
//   err_strobe    : one-cycle pulse on a rejected start
module keypad_entry_controller #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                            clk,
  input  logic                            reset,
  keypad_entry_controller_if.master       enc,
  input  logic                            start,
  input  logic                            clear,
  input  logic                            timer_busy,
  output logic [15:0]                     digits,
  output logic [2:0]                      digit_count,
  output logic                            key_strobe,
  output logic                            load_strobe,
  output logic [15:0]                     time_load,
  output logic                            err_strobe
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    RELEASE_WAIT,
    LOCKED
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [3:0]       code_q, code_d;
  logic [15:0]      digits_q, digits_d;
  logic [2:0]       count_q, count_d;
  logic [15:0]      time_load_q, time_load_d;
  logic             key_strobe_q, key_strobe_d;
  logic             load_strobe_q, load_strobe_d;
  logic             err_strobe_q, err_strobe_d;
  logic             start_arm_q, start_arm_d;
  logic             start_rise_q, start_rise_d;
  logic             accept;
  logic             start_act;

  // Next-state, counter and entry-register logic.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    code_d        = code_q;
    digits_d      = digits_q;
    count_d       = count_q;
    time_load_d   = time_load_q;
    key_strobe_d  = 1'b0;
    load_strobe_d = 1'b0;
    err_strobe_d  = 1'b0;
    accept        = 1'b0;
    cnt_inc       = cnt_q + CNT_ONE;

    // start_arm_q records that start was seen low at the previous edge.
    // It resets to 0, so a start held high through reset must first be
    // observed low before its next rise counts.
    start_arm_d  = ~start;
    start_rise_d = start & start_arm_q;

    case (state_q)
      IDLE: begin
        if (!enc.enc_datavaln) begin
          code_d  = enc.enc_bcd;
          cnt_d   = CNT_ONE;
          state_d = PRESS_WAIT;
        end
      end
      PRESS_WAIT: begin
        if (enc.enc_datavaln) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (enc.enc_bcd != code_q) begin
          code_d = enc.enc_bcd;
          cnt_d  = CNT_ONE;
        end else if (cnt_inc == CNT_LAST) begin
          accept  = 1'b1;
          cnt_d   = '0;
          state_d = RELEASE_WAIT;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RELEASE_WAIT: begin
        if (!enc.enc_datavaln) begin
          cnt_d = '0;
        end else if (cnt_inc == CNT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      LOCKED: begin
        // Leave through RELEASE_WAIT so a key held across the countdown
        // has to be released before it can be accepted.
        if (!timer_busy) begin
          cnt_d   = '0;
          state_d = RELEASE_WAIT;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    // Clear aborts a pending press.
    if (clear && (state_q == PRESS_WAIT)) begin
      cnt_d   = '0;
      state_d = RELEASE_WAIT;
    end

    if (timer_busy) begin
      cnt_d   = '0;
      state_d = LOCKED;
    end

    // Entry register: clear > start > key accept. A start that coincides
    // with an accept works on the pre-accept digits and drops the key.
    start_act = start_rise_q && !timer_busy && (state_q != LOCKED);

    if (clear) begin
      digits_d = '0;
      count_d  = '0;
    end else if (start_act) begin
      if ((count_q == 3'd0) || (digits_q[7:4] > 4'd5)) begin
        err_strobe_d = 1'b1;
      end else begin
        load_strobe_d = 1'b1;
        time_load_d   = digits_q;
        digits_d      = '0;
        count_d       = '0;
      end
    end else if (accept && !timer_busy && (count_q < 3'd4)) begin
      digits_d     = {digits_q[11:0], code_q};
      count_d      = count_q + 3'd1;
      key_strobe_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      code_q        <= '0;
      digits_q      <= '0;
      count_q       <= '0;
      time_load_q   <= '0;
      key_strobe_q  <= 1'b0;
      load_strobe_q <= 1'b0;
      err_strobe_q  <= 1'b0;
      start_arm_q   <= 1'b0;
      start_rise_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      code_q        <= code_d;
      digits_q      <= digits_d;
      count_q       <= count_d;
      time_load_q   <= time_load_d;
      key_strobe_q  <= key_strobe_d;
      load_strobe_q <= load_strobe_d;
      err_strobe_q  <= err_strobe_d;
      start_arm_q   <= start_arm_d;
      start_rise_q  <= start_rise_d;
    end
  end

  assign enc.enc_enablen = (state_q == LOCKED);
  assign digits          = digits_q;
  assign digit_count     = count_q;
  assign time_load       = time_load_q;
  assign key_strobe      = key_strobe_q;
  assign load_strobe     = load_strobe_q;
  assign err_strobe      = err_strobe_q;

endmodule

// File: tb/tb_keypad_entry_controller.sv
// Directed testbench for keypad_entry_controller with DEBOUNCE_CYCLES=4.
module tb_keypad_entry_controller;
  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        clear;
  logic        timer_busy;
  logic [15:0] digits;
  logic [2:0]  digit_count;
  logic        key_strobe;
  logic        load_strobe;
  logic [15:0] time_load;
  logic        err_strobe;

  int n_checks = 0;
  int n_errors = 0;
  int ks_seen  = 0;
  int ls_seen  = 0;
  int es_seen  = 0;

  keypad_entry_controller_if enc_if ();

  keypad_entry_controller #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk         (clk),
    .reset       (reset),
    .enc         (enc_if),
    .start       (start),
    .clear       (clear),
    .timer_busy  (timer_busy),
    .digits      (digits),
    .digit_count (digit_count),
    .key_strobe  (key_strobe),
    .load_strobe (load_strobe),
    .time_load   (time_load),
    .err_strobe  (err_strobe)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (key_strobe)  ks_seen++;
    if (load_strobe) ls_seen++;
    if (err_strobe)  es_seen++;
  endtask

  task automatic clr_seen();
    ks_seen = 0;
    ls_seen = 0;
    es_seen = 0;
  endtask

  task automatic key_on(input logic [3:0] k);
    enc_if.enc_bcd      = k;
    enc_if.enc_datavaln = 1'b0;
  endtask

  task automatic key_off();
    enc_if.enc_bcd      = 4'd0;
    enc_if.enc_datavaln = 1'b1;
  endtask

  task automatic press(input logic [3:0] k);
    key_on(k);
    repeat (DB) tick();
    key_off();
    repeat (DB) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    clear      = 1'b0;
    timer_busy = 1'b0;
    key_off();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    check_eq("rst_digits", digits, 16'h0000);
    check_eq("rst_count", digit_count, 3'd0);
    check_eq("rst_tload", time_load, 16'h0000);
    check_eq("rst_strobes", {key_strobe, load_strobe, err_strobe}, 3'b000);
    check_eq("rst_enablen", enc_if.enc_enablen, 1'b0);

    // Key 7 held 6 cycles: strobe after the 4th valid edge only
    clr_seen();
    key_on(4'd7);
    for (int i = 1; i <= 6; i++) begin
      tick();
      check_eq($sformatf("k7_strobe_e%0d", i), key_strobe, (i == 4));
    end
    key_off();
    repeat (5) tick();
    check_eq("k7_nstrobes", ks_seen, 1);
    check_eq("k7_digits", digits, 16'h0007);
    check_eq("k7_count", digit_count, 3'd1);

    // Bouncy key 3: 3 valid, 1 invalid, 3 valid, release
    clr_seen();
    key_on(4'd3);
    repeat (3) tick();
    key_off();
    tick();
    key_on(4'd3);
    repeat (3) tick();
    key_off();
    repeat (5) tick();
    check_eq("bounce_nstrobes", ks_seen, 0);
    check_eq("bounce_digits", digits, 16'h0007);

    // Code change 3->5 restarts the count
    clr_seen();
    key_on(4'd3);
    repeat (2) tick();
    key_on(4'd5);
    repeat (3) tick();
    check_eq("chg_early", ks_seen, 0);
    tick();
    check_eq("chg_strobe", key_strobe, 1'b1);
    key_off();
    repeat (DB) tick();
    check_eq("chg_digits", digits, 16'h0075);
    check_eq("chg_count", digit_count, 3'd2);

    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_eq("clr_digits", digits, 16'h0000);
    check_eq("clr_count", digit_count, 3'd0);

    // Five keys, the fifth is dropped; then a valid start
    clr_seen();
    press(4'd1);
    press(4'd2);
    press(4'd3);
    press(4'd0);
    check_eq("four_nstrobes", ks_seen, 4);
    clr_seen();
    press(4'd9);
    check_eq("fifth_nstrobes", ks_seen, 0);
    check_eq("full_digits", digits, 16'h1230);
    check_eq("full_count", digit_count, 3'd4);
    start = 1'b1;
    tick();
    check_eq("ld_edge_k", load_strobe, 1'b0);
    tick();
    check_eq("ld_strobe", load_strobe, 1'b1);
    check_eq("ld_err", err_strobe, 1'b0);
    check_eq("ld_tload", time_load, 16'h1230);
    check_eq("ld_digits", digits, 16'h0000);
    check_eq("ld_count", digit_count, 3'd0);
    start = 1'b0;
    tick();
    check_eq("ld_single", load_strobe, 1'b0);

    // Seconds tens = 7 is rejected
    press(4'd1);
    press(4'd7);
    press(4'd5);
    check_eq("bad_digits_pre", digits, 16'h0175);
    clr_seen();
    start = 1'b1;
    tick();
    tick();
    check_eq("bad_err", err_strobe, 1'b1);
    check_eq("bad_noload", ls_seen, 0);
    check_eq("bad_digits", digits, 16'h0175);
    check_eq("bad_tload", time_load, 16'h1230);
    start = 1'b0;
    tick();
    check_eq("bad_single", err_strobe, 1'b0);

    // Empty entry is rejected
    clear = 1'b1;
    tick();
    clear = 1'b0;
    start = 1'b1;
    tick();
    tick();
    check_eq("empty_err", err_strobe, 1'b1);
    start = 1'b0;
    tick();

    // Clear and start together: only the clear happens
    press(4'd2);
    check_eq("cs_digits_pre", digits, 16'h0002);
    clr_seen();
    start = 1'b1;
    clear = 1'b1;
    tick();
    tick();
    check_eq("cs_nstrobes", ls_seen + es_seen, 0);
    check_eq("cs_digits", digits, 16'h0000);
    check_eq("cs_count", digit_count, 3'd0);
    start = 1'b0;
    clear = 1'b0;
    tick();

    // Locked while the timer runs
    timer_busy = 1'b1;
    tick();
    check_eq("lock_enablen", enc_if.enc_enablen, 1'b1);
    clr_seen();
    press(4'd4);
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    tick();
    check_eq("lock_nkeys", ks_seen, 0);
    check_eq("lock_nstart", ls_seen + es_seen, 0);
    check_eq("lock_digits", digits, 16'h0000);

    // Key held while timer_busy falls: needs release plus a fresh press
    key_on(4'd4);
    tick();
    timer_busy = 1'b0;
    tick();
    check_eq("unlock_enablen", enc_if.enc_enablen, 1'b0);
    repeat (5) tick();
    check_eq("held_nkeys", ks_seen, 0);
    key_off();
    repeat (DB) tick();
    press(4'd4);
    check_eq("fresh_nkeys", ks_seen, 1);
    check_eq("fresh_digits", digits, 16'h0004);
    check_eq("fresh_count", digit_count, 3'd1);

    // Asynchronous reset in the middle of a press
    key_on(4'd8);
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    check_eq("arst_digits", digits, 16'h0000);
    check_eq("arst_count", digit_count, 3'd0);
    check_eq("arst_tload", time_load, 16'h0000);
    check_eq("arst_strobes", {key_strobe, load_strobe, err_strobe}, 3'b000);
    check_eq("arst_enablen", enc_if.enc_enablen, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    clr_seen();
    repeat (3) tick();
    check_eq("arst_discard", ks_seen, 0);
    tick();
    check_eq("arst_new_strobe", key_strobe, 1'b1);
    check_eq("arst_new_digits", digits, 16'h0008);
    key_off();
    repeat (DB) tick();

    // Start held through reset does nothing until it falls and rises
    start = 1'b1;
    reset = 1'b1;
    tick();
    #3 reset = 1'b0;
    clr_seen();
    repeat (3) tick();
    check_eq("held_start_none", ls_seen + es_seen, 0);
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    tick();
    check_eq("rearm_err", err_strobe, 1'b1);
    start = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
